// File: rtl/bru_pkg.sv
// Shared types, funct3 encodings and direction decode for the branch resolve unit.
package bru_pkg;

  localparam int unsigned F3_W = 3;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic eq;
    logic lt;
    logic ltu;
  } cmp_flags_t;

  // Width-independent part of the stage-1 payload; pc/imm are added at XLEN in the top.
  typedef struct packed {
    cmp_flags_t      flags;
    logic [F3_W-1:0] funct3;
    logic            pred;
  } s1_ctrl_t;

  function automatic logic br_taken(input cmp_flags_t f, input logic [F3_W-1:0] f3);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:  t = f.eq;
      F3_BNE:  t = !f.eq;
      F3_BLT:  t = f.lt;
      F3_BGE:  t = !f.lt;
      F3_BLTU: t = f.ltu;
      F3_BGEU: t = !f.ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic br_illegal(input logic [F3_W-1:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/br_cmp.sv
// Width-parametrised equality / signed / unsigned less-than comparator.
module br_cmp #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_c,
  output logic         lt_c,
  output logic         ltu_c
);

  assign eq_c  = (a_i == b_i);
  assign lt_c  = ($signed(a_i) < $signed(b_i));
  assign ltu_c = (a_i < b_i);

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage pipelined conditional-branch resolver with valid/ready handshake.
// Optional retire/mispredict counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] misp_count
);

  typedef struct packed {
    s1_ctrl_t        ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } s1_payload_t;

  s1_payload_t     s1_q, s1_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s2_valid_q, s2_valid_d;
  logic            taken_q, taken_d;
  logic            misp_q, misp_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] redir_q, redir_d;

  logic eq_c, lt_c, ltu_c;
  logic advance_c, s1_move_c, in_ready_c, accept_c;
  logic s2_taken_c;

  br_cmp #(.W(XLEN)) u_cmp (
    .a_i   (rs1),
    .b_i   (rs2),
    .eq_c  (eq_c),
    .lt_c  (lt_c),
    .ltu_c (ltu_c)
  );

  // Handshake: ready depends only on pipeline state, out_ready and flush.
  assign advance_c  = s2_valid_q && out_ready;
  assign s1_move_c  = s1_valid_q && (!s2_valid_q || advance_c);
  assign in_ready_c = !flush && (!s1_valid_q || !s2_valid_q || advance_c);
  assign accept_c   = in_valid && in_ready_c;
  assign s2_taken_c = br_taken(s1_q.ctrl.flags, s1_q.ctrl.funct3);

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    taken_d    = taken_q;
    misp_d     = misp_q;
    illegal_d  = illegal_q;
    target_d   = target_q;
    redir_d    = redir_q;

    if (s1_move_c) begin
      s2_valid_d = 1'b1;
      taken_d    = s2_taken_c;
      misp_d     = s2_taken_c != s1_q.ctrl.pred;
      illegal_d  = br_illegal(s1_q.ctrl.funct3);
      target_d   = s1_q.pc + s1_q.imm;
      redir_d    = s2_taken_c ? (s1_q.pc + s1_q.imm) : (s1_q.pc + XLEN'(4));
    end else if (advance_c) begin
      s2_valid_d = 1'b0;
    end

    if (accept_c) begin
      s1_valid_d            = 1'b1;
      s1_d.ctrl.flags.eq    = eq_c;
      s1_d.ctrl.flags.lt    = lt_c;
      s1_d.ctrl.flags.ltu   = ltu_c;
      s1_d.ctrl.funct3      = funct3;
      s1_d.ctrl.pred        = pred_taken;
      s1_d.pc               = pc;
      s1_d.imm              = imm;
    end else if (s1_move_c) begin
      s1_valid_d = 1'b0;
    end

    // Flush kills both stages; result registers keep their last value.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      misp_q     <= 1'b0;
      illegal_q  <= 1'b0;
      target_q   <= '0;
      redir_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      taken_q    <= taken_d;
      misp_q     <= misp_d;
      illegal_q  <= illegal_d;
      target_q   <= target_d;
      redir_q    <= redir_d;
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;

  // Counts retirements, including one that retires on a flush edge.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (advance_c) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
      if (misp_q) begin
        misp_cnt_d = misp_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign br_count   = br_cnt_q;
  assign misp_count = misp_cnt_q;
`else
  assign br_count   = '0;
  assign misp_count = '0;
`endif

  assign in_ready    = in_ready_c;
  assign out_valid   = s2_valid_q;
  assign taken       = taken_q;
  assign target      = target_q;
  assign redirect_pc = redir_q;
  assign mispredict  = misp_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit with an in-order result scoreboard.
module tb_branch_resolve_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned NVEC  = 16;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  rs1, rs2, pc, imm;
  logic [2:0]       funct3;
  logic             pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic [XLEN-1:0]  target, redirect_pc;
  logic             mispredict, illegal;
  logic [CNT_W-1:0] br_count, misp_count;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct3      (funct3),
    .pc          (pc),
    .imm         (imm),
    .pred_taken  (pred_taken),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .taken       (taken),
    .target      (target),
    .redirect_pc (redirect_pc),
    .mispredict  (mispredict),
    .illegal     (illegal),
    .br_count    (br_count),
    .misp_count  (misp_count)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, p, i;
    logic        pr;
    logic        tk;
    logic [31:0] tg, rd;
    logic        ms, il;
  } vec_t;

  vec_t        vec [NVEC];
  int          sb [$];
  int          cur_idx;
  logic        accepted;
  int          n_vec, n_err;
  int          exp_br, exp_misp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] p, input logic [31:0] i, input logic pr,
                              input logic tk, input logic [31:0] tg, input logic [31:0] rd,
                              input logic ms, input logic il);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.p = p; v.i = i; v.pr = pr;
    v.tk = tk; v.tg = tg; v.rd = rd; v.ms = ms; v.il = il;
    return v;
  endfunction

  task automatic drive(input int idx);
    cur_idx    = idx;
    in_valid   = 1'b1;
    funct3     = vec[idx].f3;
    rs1        = vec[idx].a;
    rs2        = vec[idx].b;
    pc         = vec[idx].p;
    imm        = vec[idx].i;
    pred_taken = vec[idx].pr;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Check the presented result against the scoreboard head, then advance one clock.
  task automatic tick();
    int idx;
    #1;
    accepted = 1'b0;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("dup_result", 64'd1, 64'd0);
      end else begin
        idx = sb[0];
        chk($sformatf("taken[%0d]", idx),  64'(taken),       64'(vec[idx].tk));
        chk($sformatf("target[%0d]", idx), 64'(target),      64'(vec[idx].tg));
        chk($sformatf("redir[%0d]", idx),  64'(redirect_pc), 64'(vec[idx].rd));
        chk($sformatf("misp[%0d]", idx),   64'(mispredict),  64'(vec[idx].ms));
        chk($sformatf("ill[%0d]", idx),    64'(illegal),     64'(vec[idx].il));
        if (out_ready) begin
          void'(sb.pop_front());
          exp_br++;
          if (vec[idx].ms) exp_misp++;
        end
      end
    end
    if (flush) begin
      sb.delete();
    end else if (in_valid && (in_ready === 1'b1)) begin
      sb.push_back(cur_idx);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx);
    bit done;
    done = 1'b0;
    drive(idx);
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (accepted) done = 1'b1;
    end
    if (!done) chk($sformatf("send_timeout[%0d]", idx), 64'd0, 64'd1);
  endtask

  task automatic chk_counts(input string tag);
`ifdef BRU_PERF_CNT_EN
    chk({tag, "_br"},   64'(br_count),   64'(exp_br));
    chk({tag, "_misp"}, 64'(misp_count), 64'(exp_misp));
`else
    chk({tag, "_br"},   64'(br_count),   64'd0);
    chk({tag, "_misp"}, 64'(misp_count), 64'd0);
`endif
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_br = 0; exp_misp = 0;
    //            f3      rs1           rs2           pc            imm           pr    tk    target        redirect      ms    il
    vec[0]  = mk(3'b100, 32'hFFFFFFFF, 32'h1,        32'h100,      32'h20,       1'b0, 1'b1, 32'h120,      32'h120,      1'b1, 1'b0);
    vec[1]  = mk(3'b110, 32'hFFFFFFFF, 32'h1,        32'h100,      32'h20,       1'b0, 1'b0, 32'h120,      32'h104,      1'b0, 1'b0);
    vec[2]  = mk(3'b000, 32'h5,        32'h5,        32'h200,      32'h10,       1'b1, 1'b1, 32'h210,      32'h210,      1'b0, 1'b0);
    vec[3]  = mk(3'b001, 32'h5,        32'h5,        32'h204,      32'hFFFFFFF0, 1'b1, 1'b0, 32'h1F4,      32'h208,      1'b1, 1'b0);
    vec[4]  = mk(3'b101, 32'h3,        32'hFFFFFFFE, 32'h300,      32'h40,       1'b0, 1'b1, 32'h340,      32'h340,      1'b1, 1'b0);
    vec[5]  = mk(3'b111, 32'h3,        32'hFFFFFFFE, 32'h400,      32'h8,        1'b0, 1'b0, 32'h408,      32'h404,      1'b0, 1'b0);
    vec[6]  = mk(3'b010, 32'h1,        32'h1,        32'h500,      32'h40,       1'b1, 1'b0, 32'h540,      32'h504,      1'b1, 1'b1);
    vec[7]  = mk(3'b011, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h8,        1'b0, 1'b0, 32'h4,        32'h0,        1'b0, 1'b1);
    vec[8]  = mk(3'b000, 32'h7,        32'h7,        32'hFFFFFFFC, 32'h8,        1'b1, 1'b1, 32'h4,        32'h4,        1'b0, 1'b0);
    vec[9]  = mk(3'b100, 32'h1,        32'h2,        32'h600,      32'hC,        1'b1, 1'b1, 32'h60C,      32'h60C,      1'b0, 1'b0);
    vec[10] = mk(3'b101, 32'h2,        32'h2,        32'h610,      32'h100,      1'b0, 1'b1, 32'h710,      32'h710,      1'b1, 1'b0);
    vec[11] = mk(3'b001, 32'h1,        32'h2,        32'h620,      32'hFFFFFF00, 1'b1, 1'b1, 32'h520,      32'h520,      1'b0, 1'b0);
    vec[12] = mk(3'b110, 32'h2,        32'h1,        32'h630,      32'h10,       1'b1, 1'b0, 32'h640,      32'h634,      1'b1, 1'b0);
    vec[13] = mk(3'b000, 32'h0,        32'h1,        32'h700,      32'h4,        1'b1, 1'b0, 32'h704,      32'h704,      1'b1, 1'b0);
    vec[14] = mk(3'b111, 32'h0,        32'h0,        32'h710,      32'h20,       1'b0, 1'b1, 32'h730,      32'h730,      1'b1, 1'b0);
    vec[15] = mk(3'b100, 32'h0,        32'h0,        32'h720,      32'h4,        1'b0, 1'b0, 32'h724,      32'h724,      1'b0, 1'b0);

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; cur_idx = 0; accepted = 1'b0;
    in_valid = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0; pred_taken = 1'b0;

    // Reset held two cycles.
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid),   64'd0);
    chk("rst_redirect",  64'(redirect_pc), 64'd0);
    chk("rst_target",    64'(target),      64'd0);
    chk("rst_taken",     64'(taken),       64'd0);
    chk("rst_misp",      64'(mispredict),  64'd0);
    chk("rst_illegal",   64'(illegal),     64'd0);
    chk("rst_br_count",  64'(br_count),    64'd0);
    chk("rst_misp_cnt",  64'(misp_count),  64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Latency: BLT then BLTU on the same operands.
    drive(0);
    tick();
    chk("lat_acc0", 64'(accepted), 64'd1);
    chk("lat_ov_1cyc", 64'(out_valid), 64'd0);
    drive(1);
    tick();
    chk("lat_acc1", 64'(accepted), 64'd1);
    chk("lat_ov_2cyc", 64'(out_valid), 64'd1);
    chk("lat_blt_taken", 64'(taken), 64'd1);
    chk("lat_blt_redir", 64'(redirect_pc), 64'h120);
    idle();
    tick();
    chk("lat_bltu_redir", 64'(redirect_pc), 64'h104);
    tick();

    // Back-to-back stream, one result per cycle.
    for (int i = 2; i <= 8; i++) begin
      drive(i);
      #1;
      chk($sformatf("stream_rdy[%0d]", i), 64'(in_ready), 64'd1);
      tick();
      if (i >= 3) chk($sformatf("stream_ov[%0d]", i), 64'(out_valid), 64'd1);
    end
    idle();
    tick(); tick();
    chk("stream_drained", 64'(sb.size()), 64'd0);
    chk("stream_idle_ov", 64'(out_valid), 64'd0);

    // Back-pressure: out_ready low for five cycles.
    out_ready = 1'b0;
    send(9);
    send(10);
    drive(11);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall_rdy[%0d]", k), 64'(in_ready), 64'd0);
      chk($sformatf("stall_ov[%0d]", k), 64'(out_valid), 64'd1);
      tick();
      chk($sformatf("stall_noacc[%0d]", k), 64'(accepted), 64'd0);
    end
    out_ready = 1'b1;
    send(11);
    send(12);
    idle();
    tick(); tick(); tick();
    chk("stall_drained", 64'(sb.size()), 64'd0);
    chk_counts("post_stall");

    // Flush with both stages full and a new input presented.
    out_ready = 1'b0;
    send(13);
    send(14);
    chk("fl_full_ov", 64'(out_valid), 64'd1);
    drive(15);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    idle();
    #1;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk_counts("post_flush");
    out_ready = 1'b1;
    tick(); tick();
    chk("fl_dropped", 64'(out_valid), 64'd0);
    chk("fl_sb_empty", 64'(sb.size()), 64'd0);

    chk("final_br_model", 64'(exp_br), 64'd13);
    chk("final_misp_model", 64'(exp_misp), 64'd6);
    chk_counts("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
